// File: rtl/sram_controller.sv
// sram_controller: bridges single-cycle MEM-stage load/store requests to a
// slow asynchronous 32-bit SRAM. Each request becomes a fixed-length access,
// and the pipeline is frozen via ready_o until the access completes.
module sram_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 5
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rd_en_i,
  input  logic        wr_en_i,
  input  logic [31:0] address_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        ready_o,
  output logic [16:0] sram_addr_o,
  inout  wire  [31:0] sram_dq_io,
  output logic        sram_we_n_o
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CntLast = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [16:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          we_n_q, we_n_d;
  logic          requestSeen;
  logic          dqDriveEn;

  assign requestSeen = rd_en_i | wr_en_i;

  // State register; reset aborts any access in flight and returns to IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: requests are only looked at in IDLE, and a write beats a read.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (wr_en_i) begin
          state_d = WRITE;
        end else if (rd_en_i) begin
          state_d = READ;
        end
      end
      READ, WRITE: begin
        if (cnt_q == CntLast) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: latch address/data when an access starts, count its
  // cycles, and capture the SRAM bus on the final read cycle.
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (requestSeen) begin
          cnt_d   = '0;
          addr_d  = 17'((address_i - BASE_ADDR) >> 2);
          wdata_d = write_data_i;
        end
      end
      READ: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          rdata_d = sram_dq_io;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WRITE: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
    we_n_d = (state_d != WRITE);
  end

  // Datapath registers, including the registered SRAM address and write strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_n_q  <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_n_q  <= we_n_d;
    end
  end

  // Output logic: ready releases the pipeline when idle-without-request or in DONE.
  always_comb begin
    ready_o   = ~requestSeen | (state_q == DONE);
    dqDriveEn = ~we_n_q;
  end

  assign sram_dq_io  = dqDriveEn ? wdata_q : 32'hzzzz_zzzz;
  assign read_data_o = rdata_q;
  assign sram_addr_o = addr_q;
  assign sram_we_n_o = we_n_q;

endmodule
